// File: rtl/tabellone_morra_if.sv
// tabellone_morra_if: scoreboard bus between the game engine/display side and the scoreboard
// master: drives INIZIA, CFG, MANCHE, PARTITA; observes tallies, STATO, TORNEO, FINE
// slave: the scoreboard itself, the mirror image of master
interface tabellone_morra_if #(parameter int CW = 5);
  logic          INIZIA;
  logic [3:0]    CFG;
  logic [1:0]    MANCHE;
  logic [1:0]    PARTITA;
  logic [CW-1:0] MANCHE_P1;
  logic [CW-1:0] MANCHE_P2;
  logic [CW-1:0] PAREGGI;
  logic [3:0]    PARTITE_P1;
  logic [3:0]    PARTITE_P2;
  logic [1:0]    STATO;
  logic [1:0]    TORNEO;
  logic          FINE;
  modport master (
    output INIZIA, CFG, MANCHE, PARTITA,
    input  MANCHE_P1, MANCHE_P2, PAREGGI, PARTITE_P1, PARTITE_P2, STATO, TORNEO, FINE
  );
  modport slave (
    input  INIZIA, CFG, MANCHE, PARTITA,
    output MANCHE_P1, MANCHE_P2, PAREGGI, PARTITE_P1, PARTITE_P2, STATO, TORNEO, FINE
  );
endinterface

// File: rtl/tabellone_morra.sv
// tabellone_morra: round/game tallies and tournament winner downstream of the Morra engine
// clk, rst (async, active-high); sb: slave modport carrying engine results in and tallies/status out
module tabellone_morra #(parameter int CW = 5) (
  input  logic                  clk,
  input  logic                  rst,
  tabellone_morra_if.slave      sb
);
  typedef enum logic [1:0] {IDLE = 2'b00, GIOCO = 2'b01, CHIUSO = 2'b10} stato_t;
  stato_t        stato_q;
  logic [CW-1:0] m1_q, m2_q, par_q;
  logic [3:0]    p1_q, p2_q, played_q, cfg_q;
  logic [1:0]    torneo_q;
  logic          fine_q;
  logic [3:0]    p1_d, p2_d, played_d, thr;
  logic [1:0]    torneo_d;
  logic          inc1, inc2, inc3;
  assign inc1     = sb.MANCHE == 2'b01 && !(&m1_q);
  assign inc2     = sb.MANCHE == 2'b10 && !(&m2_q);
  assign inc3     = sb.MANCHE == 2'b11 && !(&par_q);
  assign p1_d     = p1_q + {3'b000, sb.PARTITA == 2'b01};
  assign p2_d     = p2_q + {3'b000, sb.PARTITA == 2'b10};
  assign played_d = played_q + 4'd1;
  // majority threshold: more than half of the configured games
  assign thr      = {1'b0, cfg_q[3:1]} + 4'd1;
  // winner decided on post-update tallies; 00 means the tournament goes on
  assign torneo_d = p1_d == thr ? 2'b01 :
                    p2_d == thr ? 2'b10 :
                    played_d != cfg_q ? 2'b00 :
                    p1_d > p2_d ? 2'b01 :
                    p2_d > p1_d ? 2'b10 : 2'b11;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      stato_q  <= IDLE;
      m1_q     <= '0;
      m2_q     <= '0;
      par_q    <= '0;
      p1_q     <= '0;
      p2_q     <= '0;
      played_q <= '0;
      cfg_q    <= '0;
      torneo_q <= '0;
      fine_q   <= 1'b0;
    end else if (sb.INIZIA) begin
      stato_q  <= sb.CFG != 4'd0 ? GIOCO : IDLE;
      m1_q     <= '0;
      m2_q     <= '0;
      par_q    <= '0;
      p1_q     <= '0;
      p2_q     <= '0;
      played_q <= '0;
      cfg_q    <= sb.CFG;
      torneo_q <= '0;
      fine_q   <= 1'b0;
    end else begin
      case (stato_q)
        IDLE, CHIUSO: ;
        GIOCO:
          if (sb.PARTITA != 2'b00) begin
            m1_q     <= '0;
            m2_q     <= '0;
            par_q    <= '0;
            p1_q     <= p1_d;
            p2_q     <= p2_d;
            played_q <= played_d;
            if (torneo_d != 2'b00) begin
              torneo_q <= torneo_d;
              stato_q  <= CHIUSO;
              fine_q   <= 1'b1;
            end
          end else begin
            m1_q  <= m1_q + {{(CW-1){1'b0}}, inc1};
            m2_q  <= m2_q + {{(CW-1){1'b0}}, inc2};
            par_q <= par_q + {{(CW-1){1'b0}}, inc3};
          end
        default: stato_q <= IDLE;
      endcase
    end
  assign sb.MANCHE_P1  = m1_q;
  assign sb.MANCHE_P2  = m2_q;
  assign sb.PAREGGI    = par_q;
  assign sb.PARTITE_P1 = p1_q;
  assign sb.PARTITE_P2 = p2_q;
  assign sb.STATO      = stato_q;
  assign sb.TORNEO     = torneo_q;
  assign sb.FINE       = fine_q;
endmodule

// File: tb/tb_tabellone_morra.sv
// tb_tabellone_morra: directed scenarios plus randomized play against a behavioural scoreboard model
module tb_tabellone_morra;
  localparam int CW  = 5;
  localparam int SAT = (1 << CW) - 1;
  logic clk, rst;
  int total, bad;
  tabellone_morra_if #(.CW(CW)) bus ();
  tabellone_morra #(.CW(CW)) dut (.clk(clk), .rst(rst), .sb(bus));
  always #5 clk = ~clk;
  int rounds[3];
  int wins[2];
  int played, cfg_m, st, tor;
  task automatic model_reset();
    rounds = '{0, 0, 0};
    wins = '{0, 0};
    played = 0;
    cfg_m = 0;
    st = 0;
    tor = 0;
  endtask
  task automatic model_step(input bit inz, input int c, input int m, input int p);
    int need;
    if (inz) begin
      model_reset();
      cfg_m = c;
      st = (c != 0) ? 1 : 0;
    end else if (st == 1) begin
      if (p != 0) begin
        rounds = '{0, 0, 0};
        played++;
        if (p == 1) wins[0]++;
        if (p == 2) wins[1]++;
        need = cfg_m / 2 + 1;
        if (wins[0] == need) tor = 1;
        else if (wins[1] == need) tor = 2;
        else if (played == cfg_m) tor = (wins[0] > wins[1]) ? 1 : (wins[1] > wins[0]) ? 2 : 3;
        if (tor != 0) st = 2;
      end else if (m != 0 && rounds[m-1] < SAT) rounds[m-1]++;
    end
  endtask
  task automatic cycle(input bit inz, input logic [3:0] c, input logic [1:0] m, input logic [1:0] p);
    bus.INIZIA = inz;
    bus.CFG = c;
    bus.MANCHE = m;
    bus.PARTITA = p;
    @(posedge clk);
    #1;
    model_step(inz, int'(c), int'(m), int'(p));
  endtask
  task automatic test_reset();
    #12;
    total++;
    if ({bus.MANCHE_P1, bus.MANCHE_P2, bus.PAREGGI, bus.PARTITE_P1, bus.PARTITE_P2, bus.STATO, bus.TORNEO, bus.FINE} !== '0) begin
      bad++;
      $display("FAIL reset_state: got m1=%0d m2=%0d d=%0d p1=%0d p2=%0d st=%0d t=%0d f=%0d, want all 0", bus.MANCHE_P1, bus.MANCHE_P2, bus.PAREGGI, bus.PARTITE_P1, bus.PARTITE_P2, bus.STATO, bus.TORNEO, bus.FINE);
    end
    rst = 0;
    model_reset();
    cycle(1, 4'd5, 2'b00, 2'b00);
    cycle(0, 4'd0, 2'b01, 2'b00);
    cycle(0, 4'd0, 2'b01, 2'b00);
    cycle(0, 4'd0, 2'b00, 2'b01);
    cycle(0, 4'd0, 2'b10, 2'b00);
    total++;
    if (bus.MANCHE_P2 !== 5'd1 || bus.PARTITE_P1 !== 4'd1 || bus.STATO !== 2'b01) begin
      bad++;
      $display("FAIL pre_reset_tally: got m2=%0d p1=%0d st=%0d, want 1 1 1", bus.MANCHE_P2, bus.PARTITE_P1, bus.STATO);
    end
    #2;
    rst = 1;
    #1;
    total++;
    if ({bus.MANCHE_P1, bus.MANCHE_P2, bus.PAREGGI, bus.PARTITE_P1, bus.PARTITE_P2, bus.STATO, bus.TORNEO, bus.FINE} !== '0) begin
      bad++;
      $display("FAIL async_reset: got m2=%0d p1=%0d st=%0d, want all 0 before next edge", bus.MANCHE_P2, bus.PARTITE_P1, bus.STATO);
    end
    model_reset();
    @(posedge clk);
    #1;
    rst = 0;
  endtask
  task automatic test_idle();
    for (int i = 0; i < 3; i++) cycle(0, 4'd0, 2'b01, 2'b01);
    total++;
    if (bus.MANCHE_P1 !== 5'd0 || bus.PARTITE_P1 !== 4'd0 || bus.STATO !== 2'b00) begin
      bad++;
      $display("FAIL idle_ignore: got m1=%0d p1=%0d st=%0d, want 0 0 0", bus.MANCHE_P1, bus.PARTITE_P1, bus.STATO);
    end
    cycle(1, 4'd0, 2'b00, 2'b00);
    total++;
    if (bus.STATO !== 2'b00) begin
      bad++;
      $display("FAIL idle_cfg0: got st=%0d, want 0", bus.STATO);
    end
  endtask
  task automatic test_round_tally();
    cycle(1, 4'd3, 2'b00, 2'b00);
    cycle(0, 4'd0, 2'b01, 2'b00);
    cycle(0, 4'd0, 2'b01, 2'b00);
    cycle(0, 4'd0, 2'b10, 2'b00);
    cycle(0, 4'd0, 2'b11, 2'b00);
    cycle(0, 4'd0, 2'b00, 2'b00);
    total++;
    if (bus.MANCHE_P1 !== 5'd2 || bus.MANCHE_P2 !== 5'd1 || bus.PAREGGI !== 5'd1 || bus.STATO !== 2'b01) begin
      bad++;
      $display("FAIL round_tally: got m1=%0d m2=%0d d=%0d st=%0d, want 2 1 1 1", bus.MANCHE_P1, bus.MANCHE_P2, bus.PAREGGI, bus.STATO);
    end
  endtask
  task automatic test_game_priority();
    cycle(1, 4'd3, 2'b00, 2'b00);
    cycle(0, 4'd0, 2'b01, 2'b00);
    cycle(0, 4'd0, 2'b01, 2'b00);
    cycle(0, 4'd0, 2'b10, 2'b01);
    total++;
    if (bus.PARTITE_P1 !== 4'd1 || bus.MANCHE_P1 !== 5'd0 || bus.MANCHE_P2 !== 5'd0 || bus.PAREGGI !== 5'd0 || bus.STATO !== 2'b01) begin
      bad++;
      $display("FAIL game_priority: got p1=%0d m1=%0d m2=%0d d=%0d st=%0d, want 1 0 0 0 1", bus.PARTITE_P1, bus.MANCHE_P1, bus.MANCHE_P2, bus.PAREGGI, bus.STATO);
    end
  endtask
  task automatic test_majority_end();
    cycle(1, 4'd3, 2'b00, 2'b00);
    cycle(0, 4'd0, 2'b00, 2'b10);
    total++;
    if (bus.FINE !== 1'b0 || bus.TORNEO !== 2'b00 || bus.PARTITE_P2 !== 4'd1) begin
      bad++;
      $display("FAIL majority_early: got f=%0d t=%0d p2=%0d, want 0 0 1", bus.FINE, bus.TORNEO, bus.PARTITE_P2);
    end
    cycle(0, 4'd0, 2'b00, 2'b10);
    total++;
    if (bus.PARTITE_P2 !== 4'd2 || bus.TORNEO !== 2'b10 || bus.STATO !== 2'b10 || bus.FINE !== 1'b1) begin
      bad++;
      $display("FAIL majority_end: got p2=%0d t=%0d st=%0d f=%0d, want 2 2 2 1", bus.PARTITE_P2, bus.TORNEO, bus.STATO, bus.FINE);
    end
    cycle(0, 4'd0, 2'b01, 2'b01);
    total++;
    if (bus.PARTITE_P1 !== 4'd0 || bus.MANCHE_P1 !== 5'd0 || bus.TORNEO !== 2'b10 || bus.STATO !== 2'b10 || bus.FINE !== 1'b1) begin
      bad++;
      $display("FAIL closed_hold: got p1=%0d m1=%0d t=%0d st=%0d f=%0d, want 0 0 2 2 1", bus.PARTITE_P1, bus.MANCHE_P1, bus.TORNEO, bus.STATO, bus.FINE);
    end
  endtask
  task automatic test_draw_end();
    cycle(1, 4'd2, 2'b00, 2'b00);
    cycle(0, 4'd0, 2'b00, 2'b01);
    cycle(0, 4'd0, 2'b00, 2'b10);
    total++;
    if (bus.TORNEO !== 2'b11 || bus.FINE !== 1'b1) begin
      bad++;
      $display("FAIL draw_cfg2: got t=%0d f=%0d, want 3 1", bus.TORNEO, bus.FINE);
    end
    cycle(1, 4'd4, 2'b00, 2'b00);
    cycle(0, 4'd0, 2'b00, 2'b11);
    cycle(0, 4'd0, 2'b00, 2'b11);
    cycle(0, 4'd0, 2'b00, 2'b01);
    total++;
    if (bus.FINE !== 1'b0 || bus.STATO !== 2'b01) begin
      bad++;
      $display("FAIL draw_cfg4_open: got f=%0d st=%0d, want 0 1", bus.FINE, bus.STATO);
    end
    cycle(0, 4'd0, 2'b00, 2'b10);
    total++;
    if (bus.TORNEO !== 2'b11 || bus.FINE !== 1'b1 || bus.STATO !== 2'b10) begin
      bad++;
      $display("FAIL draw_cfg4_end: got t=%0d f=%0d st=%0d, want 3 1 2", bus.TORNEO, bus.FINE, bus.STATO);
    end
  endtask
  task automatic test_saturation_restart();
    cycle(1, 4'd1, 2'b00, 2'b00);
    for (int i = 0; i < 40; i++) cycle(0, 4'd0, 2'b11, 2'b00);
    total++;
    if (bus.PAREGGI !== 5'd31 || bus.MANCHE_P1 !== 5'd0) begin
      bad++;
      $display("FAIL saturation: got d=%0d m1=%0d, want 31 0", bus.PAREGGI, bus.MANCHE_P1);
    end
    cycle(0, 4'd0, 2'b00, 2'b01);
    total++;
    if (bus.TORNEO !== 2'b01 || bus.STATO !== 2'b10 || bus.PAREGGI !== 5'd0) begin
      bad++;
      $display("FAIL cfg1_close: got t=%0d st=%0d d=%0d, want 1 2 0", bus.TORNEO, bus.STATO, bus.PAREGGI);
    end
    cycle(1, 4'd0, 2'b01, 2'b01);
    total++;
    if ({bus.MANCHE_P1, bus.MANCHE_P2, bus.PAREGGI, bus.PARTITE_P1, bus.PARTITE_P2, bus.STATO, bus.TORNEO, bus.FINE} !== '0) begin
      bad++;
      $display("FAIL restart_cfg0: got p1=%0d st=%0d t=%0d f=%0d, want all 0", bus.PARTITE_P1, bus.STATO, bus.TORNEO, bus.FINE);
    end
  endtask
  task automatic test_random();
    logic [3:0] c;
    logic [1:0] m, p;
    bit inz;
    for (int i = 0; i < 1500; i++) begin
      inz = ($urandom_range(0, 24) == 0);
      c = 4'($urandom_range(0, 15));
      m = 2'($urandom);
      p = ($urandom_range(0, 5) == 0) ? 2'($urandom) : 2'b00;
      cycle(inz, c, m, p);
      total++;
      if (int'(bus.MANCHE_P1) != rounds[0] || int'(bus.MANCHE_P2) != rounds[1] || int'(bus.PAREGGI) != rounds[2]) begin
        bad++;
        $display("FAIL rnd_rounds @%0d: got %0d/%0d/%0d, want %0d/%0d/%0d", i, bus.MANCHE_P1, bus.MANCHE_P2, bus.PAREGGI, rounds[0], rounds[1], rounds[2]);
      end
      total++;
      if (int'(bus.PARTITE_P1) != wins[0] || int'(bus.PARTITE_P2) != wins[1]) begin
        bad++;
        $display("FAIL rnd_games @%0d: got %0d/%0d, want %0d/%0d", i, bus.PARTITE_P1, bus.PARTITE_P2, wins[0], wins[1]);
      end
      total++;
      if (int'(bus.STATO) != st || int'(bus.TORNEO) != tor || bus.FINE !== (st == 2)) begin
        bad++;
        $display("FAIL rnd_status @%0d: got st=%0d t=%0d f=%0d, want st=%0d t=%0d f=%0d", i, bus.STATO, bus.TORNEO, bus.FINE, st, tor, st == 2);
      end
    end
  endtask
  initial begin
    clk = 0;
    rst = 1;
    total = 0;
    bad = 0;
    bus.INIZIA = 0;
    bus.CFG = '0;
    bus.MANCHE = '0;
    bus.PARTITA = '0;
    model_reset();
    test_reset();
    test_idle();
    test_round_tally();
    test_game_priority();
    test_majority_end();
    test_draw_end();
    test_saturation_restart();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/tabellone_morra.md
Name: tabellone_morra

Overview:
Scoreboard stage directly downstream of the Morra Cinese game engine. It consumes the registered per-round MANCHE and per-game PARTITA results, plus the INIZIA/configuration word. It keeps round and game tallies for both players, detects the end of the tournament, and publishes the tournament winner. Its outputs drive the display/status logic.

Parameters:
CW, 5, width of the per-game round counters (MANCHE_P1, MANCHE_P2, PAREGGI); counters saturate at 2^CW-1.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-high
INIZIA  input  1  configuration/restart strobe, same signal that drives the game engine
CFG  input  4  number of games in the tournament ({PRIMO,SECONDO} during INIZIA); sampled only when INIZIA=1
MANCHE  input  2  round result from game engine: 00 none/invalid, 01 player 1, 10 player 2, 11 draw
PARTITA  input  2  game result from game engine: 00 none, 01 player 1, 10 player 2, 11 draw
MANCHE_P1  output  CW  rounds won by player 1 in the current game
MANCHE_P2  output  CW  rounds won by player 2 in the current game
PAREGGI  output  CW  drawn rounds in the current game
PARTITE_P1  output  4  games won by player 1 in the tournament
PARTITE_P2  output  4  games won by player 2 in the tournament
STATO  output  2  00 IDLE, 01 GIOCO, 10 CHIUSO
TORNEO  output  2  tournament winner: 00 undecided, 01 player 1, 10 player 2, 11 draw
FINE  output  1  high while STATO=CHIUSO

Behaviour:
- Single clock domain, synchronous to clk. rst is asynchronous and active-high.
- Reset values: all counters 0, internal games-played counter 0, stored CFG 0, STATO=IDLE, TORNEO=00, FINE=0.
- All outputs are registered. The effect of inputs sampled at edge N is visible right after edge N, so latency is one edge.
- INIZIA=1 has top priority in any state. On that edge:
  - store CFG;
  - clear all counters, the games-played counter and TORNEO;
  - MANCHE and PARTITA are ignored;
  - next state is GIOCO if CFG!=0, else IDLE.
- IDLE: ignore MANCHE and PARTITA. Leave only on INIZIA=1 with CFG!=0.
- GIOCO, INIZIA=0, PARTITA=00:
  - MANCHE=01 increments MANCHE_P1; 10 increments MANCHE_P2; 11 increments PAREGGI; 00 changes nothing.
  - Round counters saturate at 2^CW-1 and never wrap.
- GIOCO, INIZIA=0, PARTITA!=00 (PARTITA has priority over MANCHE):
  - MANCHE is ignored on that edge; MANCHE_P1, MANCHE_P2 and PAREGGI clear to 0.
  - Games-played counter +1.
  - PARTITA=01 increments PARTITE_P1; 10 increments PARTITE_P2; 11 increments neither.
- End-of-tournament check uses the post-update values on the same edge:
  - win threshold T = floor(stored CFG/2)+1;
  - if PARTITE_P1==T: TORNEO=01;
  - else if PARTITE_P2==T: TORNEO=10;
  - else if games played==stored CFG: TORNEO=01 if P1>P2, 10 if P2>P1, 11 if equal.
  - When any of these hits, next state is CHIUSO and FINE=1 on the same edge.
- CHIUSO: hold all counters and TORNEO. Ignore MANCHE and PARTITA. Leave only on INIZIA=1.
- The 4-bit game counters cannot overflow, because the tournament closes at most at CFG≤15 games.
- Reset mid-tournament: immediate asynchronous return to reset values. No result is retained.
- STATO encoding 11 is unreachable. If it is ever entered, the block goes to IDLE on the next edge.

Test Plan:
- Reset/idle: assert rst mid-GIOCO with counters non-zero → all outputs 0 and STATO=00 immediately, before the next edge. In IDLE, MANCHE=01 for 3 cycles → MANCHE_P1 stays 0.
- Round tally: INIZIA=1 with CFG=3, then MANCHE sequence 01,01,10,11,00 → MANCHE_P1=2, MANCHE_P2=1, PAREGGI=1, STATO=01.
- Game close priority: MANCHE_P1=2, then one cycle with PARTITA=01 and MANCHE=10 → PARTITE_P1=1, MANCHE_P2 stays 0, all round counters 0.
- Majority end: CFG=3, PARTITA=10 twice → PARTITE_P2=2, TORNEO=10, STATO=10, FINE=1 after the 2nd edge. A further PARTITA=01 → no change.
- Draw end: CFG=2, PARTITA=01 then 10 → TORNEO=11, FINE=1. CFG=4, PARTITA 11,11,01,10 → TORNEO=11 after the 4th game.
- Saturation/restart: CW=5, 40 cycles of MANCHE=11 → PAREGGI=31. In CHIUSO, INIZIA=1 with CFG=0 → counters cleared, TORNEO=00, STATO=00, FINE=0.
